// File: rtl/fpga_seq_pkg.sv
// Shared types and constants for the FPGA reset/boot sequencer.
//   seq_state_e : sequencer state encoding, also exported on state_o for debug
//   SYNC_STAGES : depth of the asynchronous-input synchronisers
package fpga_seq_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fpga_debounce.sv
// Button synchroniser and debouncer.
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset
//   btn_raw    : raw, asynchronous, bouncing button level
//   btn_stable : debounced level; follows the synchronised button only after
//                it has disagreed for DEBOUNCE_CYCLES consecutive cycles
module fpga_debounce
  import fpga_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   btn_sync;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      btn_stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      if (btn_sync == btn_stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= btn_sync;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_reset_boot_sequencer.sv
// Reset and run-status controller between the clock wizard and the SoC.
// Holds the SoC in reset until PLL lock plus a hold time, debounces the board
// reset button, latches the SoC exit status and drives a status LED.
//   clk_i        : clock-wizard output clock
//   rst_ni       : asynchronous active-low block reset
//   pll_locked_i : clock-wizard lock (asynchronous)
//   rst_btn_i    : raw board reset button, active-high (asynchronous)
//   exit_valid_i : SoC exit strobe
//   exit_value_i : SoC exit value, sampled with exit_valid_i
//   soc_rst_no   : registered active-low SoC reset
//   exit_code_o  : latched first exit value
//   exit_done_o  : high while in DONE
//   status_led_o : state indication LED
//   state_o      : current state encoding
module fpga_reset_boot_sequencer
  import fpga_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned RESET_HOLD_CYCLES = 1024,
  parameter int unsigned LED_COUNT_LENGTH  = 27
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pll_locked_i,
  input  logic        rst_btn_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        soc_rst_no,
  output logic [31:0] exit_code_o,
  output logic        exit_done_o,
  output logic        status_led_o,
  output logic [1:0]  state_o
);

  localparam int unsigned HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  seq_state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]      lock_sync_q;
  logic                        lock_sync;
  logic                        btn_stable;
  logic [HW-1:0]               hold_cnt_q;
  logic [LED_COUNT_LENGTH-1:0] led_cnt_q;
  logic                        hold_entry;
  logic                        exit_take;

  assign lock_sync = lock_sync_q[SYNC_STAGES-1];

  fpga_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .btn_raw   (rst_btn_i),
    .btn_stable(btn_stable)
  );

  // Priority: lock loss, then button, then exit strobe.
  always_comb begin
    state_d = state_q;
    if (!lock_sync) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK: state_d = HOLD;
        HOLD: begin
          if (!btn_stable && hold_cnt_q == HW'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
        end
        RUN: begin
          if (btn_stable)        state_d = HOLD;
          else if (exit_valid_i) state_d = DONE;
        end
        DONE: begin
          if (btn_stable) state_d = HOLD;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  assign hold_entry = (state_d == HOLD) && (state_q != HOLD);
  assign exit_take  = (state_q == RUN) && (state_d == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_LOCK;
      lock_sync_q <= '0;
      hold_cnt_q  <= '0;
      led_cnt_q   <= '0;
      exit_code_o <= '0;
      soc_rst_no  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      led_cnt_q   <= led_cnt_q + 1'b1;
      // Driven from the next state so the SoC reset edge coincides with the state edge.
      soc_rst_no  <= (state_d == RUN) || (state_d == DONE);
      // Counter is zero on every HOLD entry because it is held clear outside HOLD.
      if (state_q != HOLD || state_d != HOLD || btn_stable) hold_cnt_q <= '0;
      else                                                  hold_cnt_q <= hold_cnt_q + 1'b1;
      if (hold_entry)     exit_code_o <= '0;
      else if (exit_take) exit_code_o <= exit_value_i;
    end
  end

  assign state_o     = state_q;
  assign exit_done_o = (state_q == DONE);

  always_comb begin
    status_led_o = 1'b0;
    case (state_q)
      WAIT_LOCK: status_led_o = 1'b0;
      HOLD:      status_led_o = 1'b1;
      RUN:       status_led_o = led_cnt_q[LED_COUNT_LENGTH-1];
      DONE:      status_led_o = (exit_code_o == '0) ? 1'b1 : led_cnt_q[LED_COUNT_LENGTH-3];
      default:   status_led_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fpga_reset_boot_sequencer.sv
// Self-checking bench for fpga_reset_boot_sequencer: directed scenarios
// followed by a randomized phase, all compared against a cycle reference model.
module tb_fpga_reset_boot_sequencer;

  localparam int D = 4;
  localparam int H = 8;
  localparam int L = 6;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        rst_btn;
  logic        exit_valid;
  logic [31:0] exit_value;
  logic        soc_rst_no;
  logic [31:0] exit_code_o;
  logic        exit_done_o;
  logic        status_led_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  fpga_reset_boot_sequencer #(
    .DEBOUNCE_CYCLES  (D),
    .RESET_HOLD_CYCLES(H),
    .LED_COUNT_LENGTH (L)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .pll_locked_i(pll_locked),
    .rst_btn_i   (rst_btn),
    .exit_valid_i(exit_valid),
    .exit_value_i(exit_value),
    .soc_rst_no  (soc_rst_no),
    .exit_code_o (exit_code_o),
    .exit_done_o (exit_done_o),
    .status_led_o(status_led_o),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: states 0=wait lock, 1=hold, 2=run, 3=done.
  int          m_state;
  bit          m_soc;
  logic [31:0] m_code;
  int          m_cyc;
  bit          m_lock_mid, m_lock_sync;
  bit          m_btn_mid, m_btn_sync, m_btn_stable;
  int          m_btn_run;
  int          m_hold_quiet;

  task automatic model_reset();
    m_state = 0; m_soc = 0; m_code = 0; m_cyc = 0;
    m_lock_mid = 0; m_lock_sync = 0;
    m_btn_mid = 0; m_btn_sync = 0; m_btn_stable = 0;
    m_btn_run = 0; m_hold_quiet = 0;
  endtask

  task automatic model_step();
    int ns;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_lock_sync)        ns = 0;
      else if (m_state == 0)   ns = 1;
      else if (m_state == 1)   ns = (!m_btn_stable && m_hold_quiet == H - 1) ? 2 : 1;
      else if (m_btn_stable)   ns = 1;
      else if (m_state == 2 && exit_valid) ns = 3;
      else                     ns = m_state;
      if (ns == 1 && m_state != 1)     m_code = 0;
      else if (m_state == 2 && ns == 3) m_code = exit_value;
      m_hold_quiet = (m_state == 1 && ns == 1 && !m_btn_stable) ? m_hold_quiet + 1 : 0;
      m_soc   = (ns >= 2);
      m_state = ns;
      m_cyc++;
      if (m_btn_sync != m_btn_stable) begin
        m_btn_run++;
        if (m_btn_run == D) begin
          m_btn_stable = m_btn_sync;
          m_btn_run    = 0;
        end
      end else begin
        m_btn_run = 0;
      end
      m_lock_sync = m_lock_mid; m_lock_mid = pll_locked;
      m_btn_sync  = m_btn_mid;  m_btn_mid  = rst_btn;
    end
  endtask

  function automatic bit exp_led();
    case (m_state)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_cyc / 32) % 2) == 1;
      default: return (m_code == 0) ? 1'b1 : (((m_cyc / 8) % 2) == 1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("model_state", 32'(state_o), 32'(m_state));
    chk("model_soc_rst", 32'(soc_rst_no), 32'(m_soc));
    chk("model_exit_code", exit_code_o, m_code);
    chk("model_exit_done", 32'(exit_done_o), 32'(m_state == 3));
    chk("model_led", 32'(status_led_o), 32'(exp_led()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all();
    end
  endtask

  task automatic measure_toggle(input int budget, output int period);
    logic prev;
    int   first;
    prev   = status_led_o;
    first  = -1;
    period = -1;
    for (int t = 1; t <= budget; t++) begin
      tick();
      check_all();
      if (status_led_o !== prev) begin
        if (first < 0)        first  = t;
        else if (period < 0)  period = t - first;
      end
      prev = status_led_o;
    end
  endtask

  task automatic back_to_run();
    rst_btn = 1'b1;
    run(2 + D + 1);
    rst_btn = 1'b0;
    run(2 + D + H);
    chk("back_to_run", 32'(state_o), 32'd2);
  endtask

  initial begin
    int n;
    int period;
    rst_n = 1'b0; pll_locked = 1'b0; rst_btn = 1'b0;
    exit_valid = 1'b0; exit_value = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_soc_rst", 32'(soc_rst_no), 32'd0);
    chk("reset_led", 32'(status_led_o), 32'd0);
    check_all();

    // Lock startup
    rst_n = 1'b1; pll_locked = 1'b1;
    tick(); chk("lock_edge1", 32'(state_o), 32'd0);
    tick(); chk("lock_edge2", 32'(state_o), 32'd0);
    tick(); chk("lock_edge3_hold", 32'(state_o), 32'd1);
    chk("lock_soc_low", 32'(soc_rst_no), 32'd0);
    n = 0;
    while (soc_rst_no !== 1'b1 && n < 20) begin
      tick(); check_all(); n++;
    end
    chk("hold_length", 32'(n), 32'(H));
    chk("run_after_hold", 32'(state_o), 32'd2);
    measure_toggle(100, period);
    chk("run_blink_period", 32'(period), 32'd32);

    // Bounce rejection
    rst_btn = 1'b1; run(2);
    rst_btn = 1'b0; run(2);
    rst_btn = 1'b1; run(2);
    rst_btn = 1'b0; run(8);
    chk("bounce_reject", 32'(state_o), 32'd2);

    // Debounced press and release
    rst_btn = 1'b1;
    run(2 + D);
    chk("press_before", 32'(state_o), 32'd2);
    run(1);
    chk("press_hold", 32'(state_o), 32'd1);
    chk("press_soc_low", 32'(soc_rst_no), 32'd0);
    run(50);
    chk("held_in_hold", 32'(state_o), 32'd1);
    rst_btn = 1'b0;
    run(2 + D + H - 1);
    chk("release_before", 32'(state_o), 32'd1);
    run(1);
    chk("release_run", 32'(state_o), 32'd2);
    chk("release_soc_high", 32'(soc_rst_no), 32'd1);

    // Exit pass
    exit_valid = 1'b1; exit_value = 32'h0;
    tick();
    exit_valid = 1'b0;
    chk("pass_done_state", 32'(state_o), 32'd3);
    chk("pass_done_flag", 32'(exit_done_o), 32'd1);
    chk("pass_code", exit_code_o, 32'h0);
    chk("pass_led", 32'(status_led_o), 32'd1);
    run(20);
    chk("pass_led_steady", 32'(status_led_o), 32'd1);
    exit_valid = 1'b1; exit_value = 32'hDEAD;
    tick();
    exit_valid = 1'b0;
    chk("pass_second_exit", exit_code_o, 32'h0);

    // Exit fail
    back_to_run();
    exit_valid = 1'b1; exit_value = 32'h1;
    tick();
    exit_valid = 1'b0;
    chk("fail_code", exit_code_o, 32'h1);
    chk("fail_done_state", 32'(state_o), 32'd3);
    measure_toggle(40, period);
    chk("fail_blink_period", 32'(period), 32'd8);
    exit_valid = 1'b1; exit_value = 32'hDEAD;
    tick();
    exit_valid = 1'b0;
    chk("fail_second_exit", exit_code_o, 32'h1);

    // Back to run clears the latched code
    back_to_run();
    chk("code_cleared", exit_code_o, 32'h0);

    // Lock loss, debounced press and exit strobe all seen on the same edge
    rst_btn = 1'b1;
    run(D);
    pll_locked = 1'b0;
    run(2);
    chk("simul_pre", 32'(state_o), 32'd2);
    exit_valid = 1'b1; exit_value = 32'h55;
    tick();
    exit_valid = 1'b0;
    chk("simul_state", 32'(state_o), 32'd0);
    chk("simul_soc", 32'(soc_rst_no), 32'd0);
    chk("simul_code", exit_code_o, 32'h0);
    chk("simul_done", 32'(exit_done_o), 32'd0);
    run(3);

    // Relock with button still held, then release
    pll_locked = 1'b1;
    run(3);
    chk("relock_hold", 32'(state_o), 32'd1);
    rst_btn = 1'b0;
    run(2 + D + H);
    chk("relock_run", 32'(state_o), 32'd2);

    // Asynchronous reset between edges
    run(5);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_soc", 32'(soc_rst_no), 32'd0);
    chk("async_code", exit_code_o, 32'h0);
    chk("async_done", 32'(exit_done_o), 32'd0);
    chk("async_led", 32'(status_led_o), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    run(3);
    chk("post_reset_hold", 32'(state_o), 32'd1);
    n = 0;
    while (soc_rst_no !== 1'b1 && n < 20) begin
      tick(); check_all(); n++;
    end
    chk("post_reset_hold_len", 32'(n), 32'(H));

    // Randomized phase against the model
    for (int i = 0; i < 800; i++) begin
      if (pll_locked) begin
        if ($urandom_range(0, 99) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        pll_locked = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) rst_btn = ~rst_btn;
      exit_valid = ($urandom_range(0, 7) == 0);
      exit_value = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
